// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the UART transmit framer: FSM state
// encoding, legal parameter ranges and the frame parity helper.
package piso_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Narrower words are zero-extended by the caller, which leaves the XOR intact.
  function automatic logic frame_parity(input logic [DATA_W_MAX-1:0] word,
                                        input logic                  odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load shift register that presents the next outgoing bit at bit_out;
// LSB_FIRST picks which end of the word leaves first.
module piso_shift #(
  parameter int W         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         bit_out
);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= (LSB_FIRST != 0) ? (q >> 1) : (q << 1);
  end

  assign bit_out = (LSB_FIRST != 0) ? q[0] : q[W-1];

endmodule

// File: rtl/piso_tx_frame.sv
// UART transmit framer: start, DATA_W payload bits, optional parity, 1-2 stop bits,
// paced by an external baud tick. Define PISO_TX_PARITY_EN to add the parity bit.
module piso_tx_frame
  import piso_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_datain,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_baud_tick,
  output logic              o_serialdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("piso_tx_frame: DATA_W must be within 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("piso_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("piso_tx_frame: PARITY_ODD must be 0 or 1");
  end

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             stop_cnt;
  logic             accept, last_bit, last_stop;
  logic             load, shift, bit_inc, stop_inc;
  logic             ser_nxt, done_nxt, sh_bit;

  assign accept    = i_valid && o_ready;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  assign o_ready   = (state == IDLE);
  assign o_busy    = (state != IDLE);

`ifdef PISO_TX_PARITY_EN
  logic [DATA_W_MAX-1:0] word_wide;
  logic                  par_bit;

  always_comb begin
    word_wide             = '0;
    word_wide[DATA_W-1:0] = i_datain;
  end

  // Parity is frozen with the word at accept so later bus activity cannot disturb it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       par_bit <= 1'b0;
    else if (accept) par_bit <= frame_parity(word_wide, PARITY_ODD != 0);
  end
`endif

  piso_shift #(
    .W        (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (load),
    .shift  (shift),
    .d      (i_datain),
    .bit_out(sh_bit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)      state_nxt = ARM;
      ARM:   if (i_baud_tick) state_nxt = START;
      START: if (i_baud_tick) state_nxt = DATA;
      DATA:
        if (i_baud_tick && last_bit)
`ifdef PISO_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
`ifdef PISO_TX_PARITY_EN
      PARITY: if (i_baud_tick) state_nxt = STOP;
`endif
      STOP:  if (i_baud_tick && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each tick schedules the value the line takes for the coming bit period.
  always_comb begin
    load     = accept;
    shift    = 1'b0;
    bit_inc  = 1'b0;
    stop_inc = 1'b0;
    ser_nxt  = o_serialdata;
    done_nxt = 1'b0;
    case (state)
      IDLE: ser_nxt = 1'b1;
      ARM:  if (i_baud_tick) ser_nxt = 1'b0;
      START:
        if (i_baud_tick) begin
          ser_nxt = sh_bit;
          shift   = 1'b1;
        end
      DATA:
        if (i_baud_tick) begin
          if (last_bit) begin
`ifdef PISO_TX_PARITY_EN
            ser_nxt = par_bit;
`else
            ser_nxt = 1'b1;
`endif
          end else begin
            ser_nxt = sh_bit;
            shift   = 1'b1;
            bit_inc = 1'b1;
          end
        end
`ifdef PISO_TX_PARITY_EN
      PARITY: if (i_baud_tick) ser_nxt = 1'b1;
`endif
      STOP:
        if (i_baud_tick) begin
          if (last_stop) done_nxt = 1'b1;
          else           stop_inc = 1'b1;
        end
      default: ser_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      if (state != DATA)  bit_cnt <= '0;
      else if (bit_inc)   bit_cnt <= bit_cnt + 1'b1;
      if (state != STOP)  stop_cnt <= 1'b0;
      else if (stop_inc)  stop_cnt <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_serialdata <= 1'b1;
      o_done       <= 1'b0;
    end else begin
      o_serialdata <= ser_nxt;
      o_done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx_frame.sv
// Bench for piso_tx_frame: two configurations (8-bit LSB-first 1 stop, 5-bit MSB-first
// 2 stop odd parity) checked every cycle against a frame-list model plus literal frames.
module tb_piso_tx_frame;

`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
  `define TB_PAR(x) x
`else
  localparam int P = 0;
  `define TB_PAR(x) ""
`endif

  logic       clk = 1'b0;
  logic       rst0, rst1, v0, v1, tick;
  logic [7:0] d0;
  logic [4:0] d1;
  logic       ser0, rdy0, busy0, done0;
  logic       ser1, rdy1, busy1, done1;

  int checks = 0, failures = 0;
  int tcnt = 0;
  int done_cnt0 = 0, done_cnt1 = 0;

  always #5 clk = ~clk;

  piso_tx_frame dut0 (
    .i_clk(clk), .i_rst(rst0), .i_datain(d0), .i_valid(v0), .o_ready(rdy0),
    .i_baud_tick(tick), .o_serialdata(ser0), .o_busy(busy0), .o_done(done0)
  );

  piso_tx_frame #(.DATA_W(5), .STOP_BITS(2), .LSB_FIRST(0), .PARITY_ODD(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_datain(d1), .i_valid(v1), .o_ready(rdy1),
    .i_baud_tick(tick), .o_serialdata(ser1), .o_busy(busy1), .o_done(done1)
  );

  // Model: on accept the whole frame is laid out as a bit list; each later tick
  // puts the next list entry on the line, and the tick after the last one ends it.
  int   wv[2]  = '{8, 5};
  int   sv[2]  = '{1, 2};
  int   lsb[2] = '{1, 0};
  int   odd[2] = '{0, 1};
  logic frm[2][16];
  int   flen[2], pos[2];
  logic line_m[2], busy_m[2], done_m[2];
  logic pb[2], tp;
  logic cap0[$], cap1[$];

  task automatic mdl(input int k, input logic r, input logic v, input logic [8:0] d,
                     input logic t);
    int   n;
    logic par;
    done_m[k] = 1'b0;
    if (r) begin
      line_m[k] = 1'b1;
      busy_m[k] = 1'b0;
    end else if (!busy_m[k]) begin
      if (v) begin
        n = 0;
        frm[k][n] = 1'b0; n = n + 1;
        for (int i = 0; i < wv[k]; i++) begin
          frm[k][n] = (lsb[k] != 0) ? d[i] : d[wv[k]-1-i];
          n = n + 1;
        end
        if (P == 1) begin
          par = (odd[k] != 0);
          for (int i = 0; i < wv[k]; i++) par = par ^ d[i];
          frm[k][n] = par; n = n + 1;
        end
        for (int s = 0; s < sv[k]; s++) begin
          frm[k][n] = 1'b1; n = n + 1;
        end
        flen[k]   = n;
        pos[k]    = -1;
        busy_m[k] = 1'b1;
      end
    end else if (t) begin
      pos[k] = pos[k] + 1;
      if (pos[k] == flen[k]) begin
        busy_m[k] = 1'b0;
        done_m[k] = 1'b1;
        line_m[k] = 1'b1;
      end else begin
        line_m[k] = frm[k][pos[k]];
      end
    end
  endtask

  always @(posedge clk) begin
    pb[0] = busy0;
    pb[1] = busy1;
    tp    = tick;
    mdl(0, rst0, v0, {1'b0, d0}, tick);
    mdl(1, rst1, v1, {4'b0, d1}, tick);
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("ser0", ser0, line_m[0]);
    cmp("busy0", busy0, busy_m[0]);
    cmp("ready0", rdy0, !busy_m[0]);
    cmp("done0", done0, done_m[0]);
    cmp("ser1", ser1, line_m[1]);
    cmp("busy1", busy1, busy_m[1]);
    cmp("ready1", rdy1, !busy_m[1]);
    cmp("done1", done1, done_m[1]);
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    // One sample per bit period: the value driven right after each in-frame tick.
    if (tp && pb[0] && busy0) cap0.push_back(ser0);
    if (tp && pb[1] && busy1) cap1.push_back(ser1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input int k, input string exp);
    string act;
    act = "";
    if (k == 0) foreach (cap0[i]) act = {act, cap0[i] ? "1" : "0"};
    else        foreach (cap1[i]) act = {act, cap1[i] ? "1" : "0"};
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: line bits %s expected %s", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    tick = (tcnt == 0);
    tcnt = (tcnt + 1) % 4;
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!((k == 0) ? done0 : done1) && n < 500) begin
      step();
      n++;
    end
    chk("done_timeout", (n < 500) ? 1 : 0, 1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int n;
    n = 0;
    while (!((k == 0) ? rdy0 : rdy1) && n < 500) begin
      step();
      n++;
    end
    chk("ready_timeout", (n < 500) ? 1 : 0, 1);
    if (k == 0) begin v0 = 1'b1; d0 = d; end
    else        begin v1 = 1'b1; d1 = d[4:0]; end
    step();
    v0 = 1'b0;
    v1 = 1'b0;
    wait_done(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, dc;
    for (int k = 0; k < 2; k++) begin
      line_m[k] = 1'b1; busy_m[k] = 1'b0; done_m[k] = 1'b0;
      pb[k] = 1'b0; flen[k] = 0; pos[k] = 0;
    end
    tp = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; tick = 1'b0;
    step(); step();
    chk("reset_ser", ser0, 1);
    chk("reset_ready", rdy0, 1);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    step(); step();

    // 0xA5, LSB first, one stop bit
    cap0.delete();
    dc = done_cnt0;
    send(0, 8'hA5);
    chk_frame("frame_a5", 0, {"0", "10100101", `TB_PAR("0"), "1"});
    step();
    chk("a5_done_once", done_cnt0 - dc, 1);
    chk("a5_ready_back", rdy0, 1);

    // 0x07 under even (dut0) and odd (dut1) parity
    cap0.delete();
    send(0, 8'h07);
    chk_frame("frame_07_even", 0, {"0", "11100000", `TB_PAR("1"), "1"});
    cap1.delete();
    send(1, 8'h07);
    chk_frame("frame_07_odd", 1, {"0", "00111", `TB_PAR("0"), "11"});

    // 5-bit MSB first, two stop bits
    cap1.delete();
    send(1, 8'h13);
    chk_frame("frame_10011_msb", 1, {"0", "10011", `TB_PAR("0"), "11"});

    // valid held: 0x22 ignored while busy, then accepted on the done cycle
    cap0.delete();
    v0 = 1'b1; d0 = 8'h11;
    step();
    d0 = 8'h22;
    wait_done(0);
    chk("b2b_ready_on_done", rdy0, 1);
    step();
    v0 = 1'b0;
    wait_done(0);
    chk_frame("frame_b2b", 0, {"0", "10001000", `TB_PAR("0"), "1",
                               "0", "01000100", `TB_PAR("0"), "1"});

    // reset while data bit 3 is on the line
    cap0.delete();
    v0 = 1'b1; d0 = 8'h52;
    step();
    v0 = 1'b0;
    n = 0;
    while (cap0.size() < 5 && n < 200) begin
      step();
      n++;
    end
    chk("bit3_timeout", (n < 200) ? 1 : 0, 1);
    chk("bit3_line_low", ser0, 0);
    #1 rst0 = 1'b1;
    #1;
    chk("midrst_ser", ser0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_ready", rdy0, 1);
    chk("midrst_done", done0, 0);
    dc = done_cnt0;
    step(); step();
    rst0 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("no_done_after_rst", done_cnt0 - dc, 0);
    cap0.delete();
    send(0, 8'h3C);
    chk_frame("frame_after_rst", 0, {"0", "00111100", `TB_PAR("0"), "1"});

    // accept on the same cycle as a tick: that tick only arms
    step();
    n = 0;
    while (tick != 1'b1 && n < 10) begin
      step();
      n++;
    end
    cap1.delete();
    v1 = 1'b1; d1 = 5'b11010;
    step();
    v1 = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (ser1 == 1'b1 && n < 20);
    chk("arm_wait_cycles", n, 4);
    m = 0;
    while (ser1 == 1'b0 && m < 20) begin
      m++;
      step();
    end
    chk("start_bit_cycles", m, 4);
    wait_done(1);
    chk_frame("frame_tick_accept", 1, {"0", "11010", `TB_PAR("0"), "11"});

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx_frame.md
# piso_tx_frame

Parametrised UART transmit framer: accepts a DATA_W-bit word over a valid/ready handshake, serialises it LSB- or MSB-first, and wraps it in start, optional parity, and 1 or 2 stop bits. Bit timing comes from an external single-cycle baud-tick strobe. Sits between the TX holding logic and the pad, replacing the bare 8-bit load/shift register with a self-sequencing framer.

## Interface
Parameters:
- DATA_W, 8, payload bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- LSB_FIRST, 1, 1 = bit 0 is sent first, 0 = bit DATA_W-1 is sent first.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; has effect only with PISO_TX_PARITY_EN.

Ports:
- i_clk, input, 1, single clock; all logic is on the rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_datain, input, DATA_W, payload; sampled on the accept cycle.
- i_valid, input, 1, payload valid.
- o_ready, output, 1, framer idle; accept = i_valid && o_ready.
- i_baud_tick, input, 1, one-cycle bit-period strobe; pulses are at least 2 cycles apart.
- o_serialdata, output, 1, registered serial line; idle high.
- o_busy, output, 1, frame in progress.
- o_done, output, 1, one-cycle pulse at frame end.

## Operation
- Reset values: o_serialdata=1, o_ready=1, o_busy=0, o_done=0; state IDLE; counters 0.
- States and transitions:
  - IDLE -> ARM on accept; i_datain is loaded into the shift register; o_ready=0 and o_busy=1 from the next cycle.
  - ARM -> START on the next i_baud_tick; line driven 0.
  - START -> DATA on tick; first payload bit is driven.
  - DATA: each tick shifts out the next bit. After the tick that ends bit DATA_W-1, go to PARITY (macro defined) or STOP.
  - PARITY -> STOP on tick; the parity bit is driven until that tick.
  - STOP: line held 1; the stop counter counts ticks. The tick ending the last stop bit sets o_done=1 for one cycle and returns to IDLE; o_ready=1 in that same cycle.
- ARM exists so that every bit, including start, lasts exactly one full tick period.
- Bit counter is $clog2(DATA_W) wide and counts 0..DATA_W-1. It does not wrap past DATA_W-1.
- Parity is computed over the word as captured at accept: XOR of the bits, inverted when PARITY_ODD=1.
- i_valid while o_ready=0 is ignored; the held word is unaffected.
- i_baud_tick in IDLE is ignored.
- Accept coinciding with a tick in IDLE enters ARM; that tick is not consumed as the start bit.
- i_rst asserted mid-frame immediately forces every output to its reset value (line high). The partial frame is abandoned with no o_done.
- Illegal DATA_W or STOP_BITS values stop elaboration with an error.

## Timing
- Every o_serialdata change is registered and visible in the cycle after the tick's edge.
- Frame length after the arming tick: 1 + DATA_W + P + STOP_BITS tick periods, where P = 1 with PISO_TX_PARITY_EN and 0 without.
- Latency from accept to the falling start edge: cycles until the next tick, plus 1.
- Back-to-back frames: an accept on the o_done cycle is legal. The line then stays high until the following tick; there is no idle gap beyond the ARM wait.

## Configuration
- PISO_TX_PARITY_EN defined:
  - the PARITY state and PARITY_ODD take effect;
  - the frame carries one parity bit between the last data bit and the first stop bit.
- PISO_TX_PARITY_EN undefined:
  - there is no parity logic or state;
  - DATA goes directly to STOP;
  - PARITY_ODD is ignored.

## Structure
- Package piso_tx_pkg holds:
  - the state typedef (IDLE, ARM, START, DATA, PARITY, STOP);
  - the legal-range constants for DATA_W and STOP_BITS;
  - a parity function.
- Sub-module piso_shift: parametrised load/shift register with a direction parameter, driven by the FSM's load and shift strobes.

## Test plan
- DATA_W=8, LSB_FIRST=1, 1 stop bit, no parity, tick every 4 cycles, send 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, one per tick period; o_done once; o_ready back to 1.
- PISO_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0.
- LSB_FIRST=0, DATA_W=5, STOP_BITS=2, send 5'b10011 -> data bits 1,0,0,1,1, then two high stop periods.
- i_valid held with 0x11 then 0x22 while busy -> only 0x11 is sent. 0x22 is accepted on the o_done cycle and sent next with no extra gap.
- i_rst pulsed during data bit 3 -> o_serialdata=1 and o_busy=0 immediately; no o_done; a new frame then sends correctly.
- Accept coinciding with a tick in IDLE -> the start bit begins on the following tick and lasts exactly one tick period.
